multicycle_control_fsm: RTL and testbench

- Moore-style sequencer that drives a multi-cycle MIPS datapath: one shared memory port, instruction register, ALUOut/MDR holding registers, and a PC updated only when enabled.
- Replaces the single-cycle combinational control path.
- Decodes opcode/funct once per instruction and steps the datapath through fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 39 +++
 rtl/ctrl_output_decode.sv | 112 +++++++++++
 rtl/multicycle_control_fsm.sv | 85 ++++++++
 tb/tb_multicycle_control_fsm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode, ALU and mux-select encodings for the multicycle MIPS control FSM.
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    EXEC_I   = 4'd10,
    I_WB     = 4'd11,
    ILLEGAL  = 4'd12
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
endpackage

// File: rtl/ctrl_output_decode.sv
// ctrl_output_decode: combinational Moore output decode of state/opcode/zero/mem_ready.
// ILLEGAL_OP_TRAP_EN makes ILLEGAL a sticky trap that raises illegal_op.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic       reset,
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic       illegal_op,
`endif
  output logic       instr_retired
);
  always_comb begin
    pc_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;
    instr_retired = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_op    = 1'b0;
`endif
    // reset masks every output so a half-finished instruction never writes
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: alu_src_b = SRCB_SHIFT;
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_RTYPE;
        end
        R_WB: begin
          reg_write     = 1'b1;
          reg_dst       = 1'b1;
          instr_retired = 1'b1;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_ADD;
        end
        I_WB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WB: begin
          reg_write     = 1'b1;
          mem_to_reg    = 1'b1;
          instr_retired = 1'b1;
        end
        MEM_WR: begin
          mem_write     = 1'b1;
          iord          = 1'b1;
          instr_retired = mem_ready;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_source     = PCS_ALUOUT;
          pc_write      = opcode == OP_BNE ? ~zero : zero;
          instr_retired = 1'b1;
        end
        JUMP: begin
          pc_source     = PCS_JUMP;
          pc_write      = 1'b1;
          instr_retired = 1'b1;
        end
`ifdef ILLEGAL_OP_TRAP_EN
        ILLEGAL: illegal_op = 1'b1;
`else
        ILLEGAL: instr_retired = 1'b1;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS control sequencer (state register + next-state logic).
// ILLEGAL_OP_TRAP_EN makes unknown opcodes trap until reset and adds the illegal_op port.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic       illegal_op,
`endif
  output logic       instr_retired,
  output logic [3:0] state_o
);
  state_t state, next_state;
  // funct is decoded by ALUControl, not here
  logic funct_unused;
  assign funct_unused = ^funct;
  assign state_o = state;
  always_ff @(posedge clk)
    if (reset) state <= FETCH;
    else state <= next_state;
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE:
        case (opcode)
          OP_RTYPE:               next_state = EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI: next_state = EXEC_I;
          OP_LW, OP_SW:           next_state = MEM_ADDR;
          OP_BEQ, OP_BNE:         next_state = BRANCH;
          OP_J:                   next_state = JUMP;
          default:                next_state = ILLEGAL;
        endcase
      EXEC_R:   next_state = R_WB;
      EXEC_I:   next_state = I_WB;
      MEM_ADDR: next_state = opcode == OP_LW ? MEM_RD : MEM_WR;
      MEM_RD:   next_state = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   next_state = mem_ready ? FETCH : MEM_WR;
`ifdef ILLEGAL_OP_TRAP_EN
      ILLEGAL:  next_state = ILLEGAL;
`endif
      default:  next_state = FETCH;
    endcase
  end
  ctrl_output_decode u_dec (
    .reset         (reset),
    .state         (state),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_op    (illegal_op),
`endif
    .instr_retired (instr_retired)
  );
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed plus randomized checks against an instruction-step model.
module tb_multicycle_control_fsm;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'h00, funct = 6'h20;
  logic pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, instr_retired;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state_o;
`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_op;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef struct packed {
    logic pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic [1:0] pcs;
    logic retired;
  } ctl_t;
  ctl_t dut_ctl;
  assign dut_ctl = {pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                    alu_src_a, alu_src_b, alu_op, pc_source, instr_retired};

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .instr_retired(instr_retired), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the current step plus the queue of steps left in this instruction
  int cur = 0;
  int q[$];
  bit armed = 1'b0;
  always @(negedge clk) begin
    logic last;
    ctl_t e;
    last = cur > 1 && q.size() == 0;
    if (armed) begin
      e = '0;
      if (!reset) begin
        e.pc_write   = cur == 0 ? mem_ready : cur == 8 ? (opcode == 6'h05 ? ~zero : zero) : (cur == 9);
        e.iord       = cur == 3 || cur == 5;
        e.mem_read   = cur == 0 || cur == 3;
        e.mem_write  = cur == 5;
        e.ir_write   = cur == 0 && mem_ready;
        e.reg_write  = cur == 4 || cur == 7 || cur == 11;
        e.reg_dst    = cur == 7;
        e.mem_to_reg = cur == 4;
        e.alu_src_a  = cur == 2 || cur == 6 || cur == 8 || cur == 10;
        e.src_b      = cur == 0 ? 2'd1 : cur == 1 ? 2'd3 : (cur == 2 || cur == 10) ? 2'd2 : 2'd0;
        e.alu_op     = cur == 6 ? 3'd7 : cur == 8 ? 3'd1 : (cur == 10 && opcode == 6'h0C) ? 3'd3 :
                       (cur == 10 && opcode == 6'h0D) ? 3'd2 : 3'd0;
        e.pcs        = cur == 8 ? 2'd1 : cur == 9 ? 2'd2 : 2'd0;
        e.retired    = last && (cur != 5 || mem_ready) && !(TRAP && cur == 12);
      end
      chk("model_state", 32'(state_o), cur);
      chk("model_ctl", 32'(dut_ctl), 32'(e));
`ifdef ILLEGAL_OP_TRAP_EN
      if (!reset) chk("model_illegal_op", 32'(illegal_op), 32'(cur == 12));
`endif
    end
    if (reset) begin
      cur = 0;
      q.delete();
      armed = 1'b1;
    end else if (!armed || ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) || (TRAP && cur == 12)) begin
    end else if (cur == 0) cur = 1;
    else if (cur == 1) begin
      case (opcode)
        6'h00:               q = {6, 7};
        6'h08, 6'h0C, 6'h0D: q = {10, 11};
        6'h23:               q = {2, 3, 4};
        6'h2B:               q = {2, 5};
        6'h04, 6'h05:        q = {8};
        6'h02:               q = {9};
        default:             q = {12};
      endcase
      cur = q.pop_front();
    end else if (q.size() != 0) cur = q.pop_front();
    else cur = 0;
  end

  task automatic cyc(input logic r, input logic mr, input logic z, input logic [5:0] op, input int es);
    @(posedge clk);
    #1;
    reset = r;
    mem_ready = mr;
    zero = z;
    opcode = op;
    @(negedge clk);
    chk("dir_state", 32'(state_o), es);
  endtask

  logic [5:0] ops [9] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

  initial begin
    repeat (3) @(posedge clk);
    cyc(1, 1, 0, 6'h00, 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    // R-type: 0,1,6,7 with the write only in R_WB
    cyc(0, 1, 0, 6'h00, 0);
    chk("r_f_reg_write", 32'(reg_write), 0);
    cyc(0, 1, 0, 6'h00, 1);
    cyc(0, 1, 0, 6'h00, 6);
    chk("r_ex_alu_op", 32'(alu_op), 7);
    cyc(0, 1, 0, 6'h00, 7);
    chk("r_wb_reg_write", 32'(reg_write), 1);
    chk("r_wb_reg_dst", 32'(reg_dst), 1);
    chk("r_wb_retired", 32'(instr_retired), 1);
    // lw with two wait cycles in MEM_RD
    cyc(0, 1, 0, 6'h23, 0);
    cyc(0, 1, 0, 6'h23, 1);
    cyc(0, 1, 0, 6'h23, 2);
    cyc(0, 0, 0, 6'h23, 3);
    chk("lw_rd_iord", 32'(iord), 1);
    cyc(0, 0, 0, 6'h23, 3);
    chk("lw_rd_mem_read", 32'(mem_read), 1);
    cyc(0, 1, 0, 6'h23, 3);
    cyc(0, 1, 0, 6'h23, 4);
    chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 1);
    // beq and bne, both with zero=1
    cyc(0, 1, 1, 6'h04, 0);
    cyc(0, 1, 1, 6'h04, 1);
    cyc(0, 1, 1, 6'h04, 8);
    chk("beq_pc_write", 32'(pc_write), 1);
    chk("beq_pc_source", 32'(pc_source), 1);
    cyc(0, 1, 1, 6'h05, 0);
    cyc(0, 1, 1, 6'h05, 1);
    cyc(0, 1, 1, 6'h05, 8);
    chk("bne_pc_write", 32'(pc_write), 0);
    chk("bne_pc_source", 32'(pc_source), 1);
    // FETCH stall for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 6'h00, 0);
      chk("stall_ir_write", 32'(ir_write), 0);
      chk("stall_pc_write", 32'(pc_write), 0);
    end
    cyc(0, 1, 0, 6'h00, 0);
    chk("ready_ir_write", 32'(ir_write), 1);
    chk("ready_pc_write", 32'(pc_write), 1);
    cyc(0, 1, 0, 6'h00, 1);
    cyc(0, 1, 0, 6'h00, 6);
    cyc(0, 1, 0, 6'h00, 7);
    // reset while sw waits in MEM_WR
    cyc(0, 1, 0, 6'h2B, 0);
    cyc(0, 1, 0, 6'h2B, 1);
    cyc(0, 1, 0, 6'h2B, 2);
    cyc(0, 0, 0, 6'h2B, 5);
    chk("sw_mem_write", 32'(mem_write), 1);
    cyc(1, 1, 0, 6'h2B, 5);
    chk("sw_rst_mem_write", 32'(mem_write), 0);
    chk("sw_rst_retired", 32'(instr_retired), 0);
    cyc(0, 1, 0, 6'h2B, 0);
    // illegal opcode
    cyc(0, 1, 0, 6'h3F, 1);
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 6'h3F, 12);
      chk("trap_illegal_op", 32'(illegal_op), 1);
      chk("trap_retired", 32'(instr_retired), 0);
    end
    cyc(1, 1, 0, 6'h3F, 12);
    cyc(0, 1, 0, 6'h3F, 0);
`else
    cyc(0, 1, 0, 6'h3F, 12);
    chk("nop_retired", 32'(instr_retired), 1);
    cyc(0, 1, 0, 6'h3F, 0);
`endif
    // randomized traffic; a new opcode is presented only while fetching
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      reset = $urandom_range(0, 99) < 3;
      mem_ready = $urandom_range(0, 9) < 7;
      zero = 1'($urandom);
      if (cur == 0) begin
        int r;
        r = $urandom_range(0, 9);
        opcode = r == 9 ? 6'($urandom) : ops[r];
        funct = 6'($urandom);
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
